// File: rtl/dcache_refill_ctrl.sv
// Data cache refill/store controller: services load misses with a single-word
// memory read followed by a one-cycle line fill strobe, and forwards
// write-through stores (SB/SW) to memory with byte lane enables.
// Optional feature: define DCACHE_MISS_COUNTER_EN to build a saturating
// counter of accepted refills on missCount; otherwise missCount is tied to 0.
module dcache_refill_ctrl #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   // cache side
   input  logic                  missReq,
   input  logic                  storeReq,
   input  logic                  storeByte,
   input  logic [ADDR_WIDTH-1:0] reqAddr,
   input  logic [DATA_WIDTH-1:0] storeData,
   output logic                  stall,
   output logic                  fillEn,
   output logic [ADDR_WIDTH-1:0] fillAddr,
   output logic [DATA_WIDTH-1:0] fillData,
   output logic                  busy,
   output logic [31:0]           missCount,
   // memory side
   output logic                  memRdEn,
   output logic                  memWrEn,
   output logic [ADDR_WIDTH-1:0] memAddr,
   output logic [DATA_WIDTH-1:0] memWrData,
   output logic [3:0]            memByteEn,
   input  logic                  memAck,
   input  logic [DATA_WIDTH-1:0] memRdData
);

   localparam int unsigned BE_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RD_REQ = 2'd1,
      FILL   = 2'd2,
      WR_REQ = 2'd3
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  sb_q, sb_d;
   logic                  rd_en_q, rd_en_d;
   logic                  wr_en_q, wr_en_d;
   logic                  fill_en_q, fill_en_d;
   logic                  busy_q, busy_d;
   logic [BE_WIDTH-1:0]   be_q, be_d;

   // Next-state, request capture and next values of the registered outputs
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      sb_d    = sb_q;

      unique case (state_q)
         IDLE: begin
            // a load miss outranks a store; the store stays presented under stall
            if (missReq) begin
               addr_d  = reqAddr;
               state_d = RD_REQ;
            end else if (storeReq) begin
               addr_d  = reqAddr;
               wdata_d = storeData;
               sb_d    = storeByte;
               state_d = WR_REQ;
            end
         end
         RD_REQ: begin
            if (memAck) begin
               rdata_d = memRdData;
               state_d = FILL;
            end
         end
         FILL: begin
            state_d = IDLE;
         end
         WR_REQ: begin
            if (memAck) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // outputs are registered copies of the decoded next state
      rd_en_d   = (state_d == RD_REQ);
      wr_en_d   = (state_d == WR_REQ);
      fill_en_d = (state_d == FILL);
      busy_d    = (state_d != IDLE);
      if (state_d == WR_REQ) begin
         be_d = sb_d ? (BE_WIDTH'(1) << addr_d[1:0]) : {BE_WIDTH{1'b1}};
      end else begin
         be_d = '0;
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         sb_q      <= 1'b0;
         rd_en_q   <= 1'b0;
         wr_en_q   <= 1'b0;
         fill_en_q <= 1'b0;
         busy_q    <= 1'b0;
         be_q      <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         sb_q      <= sb_d;
         rd_en_q   <= rd_en_d;
         wr_en_q   <= wr_en_d;
         fill_en_q <= fill_en_d;
         busy_q    <= busy_d;
         be_q      <= be_d;
      end
   end

`ifdef DCACHE_MISS_COUNTER_EN
   logic [31:0] miss_cnt_q, miss_cnt_d;
   logic        miss_start_c;

   // Count IDLE->RD_REQ transitions, saturating at all-ones
   always_comb begin
      miss_start_c = (state_q == IDLE) && missReq;
      miss_cnt_d   = miss_cnt_q;
      if (miss_start_c && (miss_cnt_q != 32'hFFFF_FFFF)) begin
         miss_cnt_d = miss_cnt_q + 32'd1;
      end
   end

   // Refill counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         miss_cnt_q <= '0;
      end else begin
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign missCount = miss_cnt_q;
`else
   assign missCount = 32'd0;
`endif

   // Pipeline freeze must react in the same cycle as the request
   assign stall     = (state_q != IDLE) || missReq || storeReq;

   assign fillEn    = fill_en_q;
   assign fillAddr  = addr_q;
   assign fillData  = rdata_q;
   assign busy      = busy_q;
   assign memRdEn   = rd_en_q;
   assign memWrEn   = wr_en_q;
   assign memAddr   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
   assign memWrData = wdata_q;
   assign memByteEn = be_q;

endmodule

// File: doc/dcache_refill_ctrl.md
DCACHE_REFILL_CTRL -- requirements
Module: dcache_refill_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, width of all address ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of all data ports.
REQ-003 SHALL have clock and reset ports as follows:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have cache-side ports as follows:
- missReq  input  1  load miss from the data cache in the M stage.
- storeReq  input  1  store from the M stage (write-through).
- storeByte  input  1  store is SB (1) or SW (0).
- reqAddr  input  ADDR_WIDTH  byte address of the request.
- storeData  input  DATA_WIDTH  store data.
- stall  output  1  freeze pipeline stages F through M.
- fillEn  output  1  one-cycle cache line write strobe.
- fillAddr  output  ADDR_WIDTH  address of the line being filled.
- fillData  output  DATA_WIDTH  returned memory word.
- busy  output  1  FSM not in IDLE.
- missCount  output  32  count of accepted refills.
REQ-005 SHALL have memory-side ports as follows:
- memRdEn  output  1  read request, held until acknowledged.
- memWrEn  output  1  write request, held until acknowledged.
- memAddr  output  ADDR_WIDTH  word-aligned address, with bits [1:0] forced to 0.
- memWrData  output  DATA_WIDTH  write data.
- memByteEn  output  4  byte lane enables.
- memAck  input  1  request done; read data is valid in the same cycle.
- memRdData  input  DATA_WIDTH  read data.

Function
REQ-006 SHALL implement an FSM with states IDLE, RD_REQ, FILL and WR_REQ.
REQ-007 IDLE: if missReq=1, SHALL capture reqAddr and go to RD_REQ; otherwise, if storeReq=1, SHALL capture reqAddr, storeData and storeByte and go to WR_REQ; otherwise SHALL stay in IDLE.
REQ-008 When missReq and storeReq are both 1 in IDLE, missReq SHALL win and the store SHALL be ignored; the store stays presented because stall=1.
REQ-009 RD_REQ: SHALL hold memRdEn=1 with memAddr set to the captured address; on memAck=1, SHALL register memRdData and go to FILL.
REQ-010 FILL: SHALL drive fillEn=1 for exactly one cycle, with fillAddr set to the captured address and fillData set to the registered data, then go to IDLE.
REQ-011 WR_REQ: SHALL hold memWrEn=1; memWrData SHALL equal the captured storeData.
REQ-012 In WR_REQ, memByteEn SHALL be the one-hot of addr[1:0] when storeByte=1, and 4'b1111 otherwise; on memAck=1, SHALL go to IDLE.
REQ-013 stall SHALL equal (state!=IDLE) OR (state==IDLE AND (missReq OR storeReq)), and SHALL be combinational.
REQ-014 stall SHALL remain 1 through FILL, and SHALL be 0 in the first IDLE cycle after FILL unless a new request arrives.
REQ-015 Load miss latency SHALL be 3+k stall cycles, where k is the number of RD_REQ cycles before memAck.
REQ-016 Store latency SHALL be 2+k stall cycles.
REQ-017 memRdEn and memWrEn SHALL never both be 1.
REQ-018 Both enables SHALL be 0 in IDLE and FILL.
REQ-019 missReq and storeReq SHALL be ignored in any state other than IDLE.
REQ-020 memAck SHALL be ignored in IDLE and FILL.
REQ-021 All registered outputs SHALL change only on rising clk.
REQ-022 memAddr, fillAddr and memWrData SHALL be stable for the whole of a request.

Reset
REQ-023 When rst=1 at a clock edge, state SHALL become IDLE and captured address/data SHALL become 0.
REQ-024 After reset, fillEn, memRdEn, memWrEn and busy SHALL be 0, memByteEn SHALL be 0, and missCount SHALL be 0.
REQ-025 Reset during RD_REQ, WR_REQ or FILL SHALL abort the operation with no fillEn pulse, and memory enables SHALL be low in the next cycle.
REQ-026 rst SHALL take priority over all other inputs in the same cycle.

Configuration
REQ-027 Macro DCACHE_MISS_COUNTER_EN defined: missCount SHALL increment by 1 on each IDLE->RD_REQ transition, and SHALL saturate at 32'hFFFFFFFF.
REQ-028 Macro DCACHE_MISS_COUNTER_EN undefined: missCount SHALL be constant 0 and no counter register SHALL be synthesised.

Verification
REQ-029 Load miss: missReq=1, reqAddr=0x00000105, memAck on the 2nd RD_REQ cycle with memRdData=0xA1B2C3D4 -> memAddr=0x00000104, then fillEn one cycle with fillAddr=0x105 and fillData=0xA1B2C3D4, and stall high for 4 cycles.
REQ-030 Store byte: storeReq=1, storeByte=1, reqAddr=0x22, storeData=0x000000EE, memAck immediate -> memWrEn one cycle, memByteEn=4'b0100, memWrData=0xEE, stall 2 cycles.
REQ-031 Simultaneous requests: missReq=1 and storeReq=1 in IDLE -> read serviced first, then the store is accepted in the following IDLE cycle, with no lost write.
REQ-032 Reset mid-read: rst=1 during the 3rd RD_REQ cycle -> IDLE next cycle, memRdEn=0, no fillEn pulse, stall=0.
REQ-033 Counter: 5 load misses -> missCount=5 with DCACHE_MISS_COUNTER_EN defined, and 0 without it.
